aes256_key_sched_ctrl: RTL and testbench
========================================

Name: aes256_key_sched_ctrl

Overview:
Sequencer for the combinational 256-bit key-expansion stage (rc, key -> keyout). On a start request it steps the externally instantiated expander through rc = 1..7. It stores the original key plus the seven 256-bit expansion results, then serves the 15 AES-256 round keys (128 bit each) to the round datapath through a registered indexed read port. It sits between the key input interface and the encryption round controller.

Parameters:
EXP_LAT, 1, clock cycles allowed for the combinational expander to settle per step (1..15)
NUM_STEPS, 7, expansion steps per key; fixed for AES-256, not for override

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a new schedule; sampled only when not busy
key_in  in  256  cipher key, captured on the accepted start edge
exp_rc  out  4  round-constant index driven to the expander
exp_key  out  256  key word driven to the expander
exp_keyout  in  256  expander result
rk_idx  in  4  round key index 0..14
rk_out  out  128  round key selected by rk_idx, registered
busy  out  1  schedule in progress
done  out  1  one-cycle pulse when all keys are stored
keys_valid  out  1  storage holds a complete schedule

Behaviour:
- One clock domain; reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset values:
  - State is IDLE.
  - busy=0, done=0, keys_valid=0.
  - exp_rc=0, exp_key=0, rk_out=0.
  - Step counter and wait counter are 0.
  - All 8 storage slots (8x256) are 0.
- States and transitions:
  - IDLE: start=1 -> LOAD actions on the same edge: slot0<=key_in, exp_key<=key_in, exp_rc<=1, busy<=1, keys_valid<=0, wait counter<=0. Next state EXPAND.
  - EXPAND: wait counter increments each cycle. When it reaches EXP_LAT-1, on that edge:
    - slot[exp_rc]<=exp_keyout
    - exp_key<=exp_keyout
    - wait counter<=0
    - If exp_rc==7: busy<=0, done<=1, keys_valid<=1, exp_rc<=0, next state IDLE.
    - Otherwise: exp_rc<=exp_rc+1.
- Latency: with start accepted at edge T0, slot k is written at edge T0+k*EXP_LAT. done is high for exactly the cycle after edge T0+7*EXP_LAT. For EXP_LAT=1 that is 7 cycles after the accepting edge.
- start while busy=1 is ignored; no queuing, no restart.
- start asserted in the cycle done is high is accepted normally, since the state is already IDLE.
- A new accepted start clears keys_valid immediately. Slots 1..7 are overwritten progressively; reads return 0 until keys_valid is set again.
- Read port, 1-cycle latency; rk_out updates every cycle:
  - keys_valid=0: rk_out<=0.
  - rk_idx<=14: round key 2i is slot[i][255:128]; round key 2i+1 is slot[i][127:0].
  - rk_idx=15: rk_out<=0.
- rst_n low mid-schedule aborts immediately. All outputs and storage return to reset values, and no done pulse is emitted.
- exp_key and exp_rc are held stable for all EXP_LAT cycles of a step.

Optional Feature:
- Macro: KSCHED_ZEROIZE_EN.
- With the macro defined:
  - Extra input port zeroize (1 bit).
  - zeroize=1 on any edge clears all slots, rk_out, exp_key, exp_rc, busy, done, keys_valid and returns the state to IDLE, same as reset.
  - zeroize has priority over start; rst_n has priority over zeroize.
- Without the macro: the port does not exist, and storage is cleared only by rst_n.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> busy=0, done=0, keys_valid=0, rk_out=0, exp_rc=0.
- FIPS-197 key 000102...1f, EXP_LAT=1, then sweep rk_idx 0..14 -> done exactly 7 cycles after the start edge.
  - rk 0 = 000102030405060708090a0b0c0d0e0f.
  - rk 1 = 101112131415161718191a1b1c1d1e1f.
  - rk 14 = 24fc79ccbf0979e9371ac23c6d68de36.
- Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk 2 = 9ba354118e6925afa51a8b5f2067fcde. With EXP_LAT=3, done appears 21 cycles after start and exp_rc steps 1..7, each value held 3 cycles.
- Start pulsed during busy (step 3) -> ignored; schedule and keys match the first key; rk_idx=15 -> rk_out=0.
- rst_n low at step 4, then start with a new key -> no done from the aborted run; new schedule correct; keys_valid=0 between the runs.
- With KSCHED_ZEROIZE_EN: zeroize after done -> next-cycle rk_out=0 for all indices and keys_valid=0. zeroize together with start -> stays IDLE.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl
//   Sequencer for an external combinational AES-256 key-expansion stage. On an
//   accepted start it drives the expander through rc = 1..7, giving each step
//   EXP_LAT cycles to settle. It stores the original key plus the seven 256-bit
//   results in eight slots, then serves the 15 round keys through a registered
//   indexed read port.
//
// Ports
//   clk, rst_n        clock and synchronous active-low reset
//   start, key_in     schedule request and cipher key (taken only when idle)
//   exp_rc, exp_key   round-constant index and key word to the expander
//   exp_keyout        expander result
//   rk_idx, rk_out    round key index 0..14 and registered 128-bit round key
//   busy, done        schedule in progress / one-cycle completion pulse
//   keys_valid        storage holds a complete schedule
//
// Build option
//   KSCHED_ZEROIZE_EN adds a zeroize input that clears all state like reset
//   (rst_n > zeroize > start in priority). Without it only rst_n clears storage.
module aes256_key_sched_ctrl #(
  parameter int unsigned EXP_LAT   = 1,
  parameter int unsigned NUM_STEPS = 7
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef KSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [255:0] key_in,
  output logic [3:0]   exp_rc,
  output logic [255:0] exp_key,
  input  logic [255:0] exp_keyout,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  localparam logic [3:0] LastWait = 4'(EXP_LAT - 1);
  localparam logic [3:0] LastStep = 4'(NUM_STEPS);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       state;
  logic [3:0]   wait_cnt;
  logic [255:0] slots [0:7];
  logic         clear;
  logic         accept;
  logic         read_ok;

`ifdef KSCHED_ZEROIZE_EN
  assign clear = ~rst_n | zeroize;
`else
  assign clear = ~rst_n;
`endif

  assign accept  = (state == StIdle) && start;
  // A start accepted on this edge invalidates the stored schedule at once, so
  // the read launched on the same edge already returns zero.
  assign read_ok = keys_valid && !accept && (rk_idx != 4'd15);

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= StIdle;
      wait_cnt   <= 4'd0;
      exp_rc     <= 4'd0;
      exp_key    <= '0;
      rk_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        slots[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // Slot i holds round keys 2i (upper half) and 2i+1 (lower half).
      if (read_ok) begin
        rk_out <= rk_idx[0] ? slots[rk_idx[3:1]][127:0] : slots[rk_idx[3:1]][255:128];
      end else begin
        rk_out <= '0;
      end

      unique case (state)
        StIdle: begin
          if (start) begin
            slots[0]   <= key_in;
            exp_key    <= key_in;
            exp_rc     <= 4'd1;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            wait_cnt   <= 4'd0;
            state      <= StExpand;
          end
        end
        StExpand: begin
          // exp_rc/exp_key stay constant while the expander settles.
          if (wait_cnt == LastWait) begin
            slots[exp_rc[2:0]] <= exp_keyout;
            exp_key            <= exp_keyout;
            wait_cnt           <= 4'd0;
            if (exp_rc == LastStep) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              keys_valid <= 1'b1;
              exp_rc     <= 4'd0;
              state      <= StIdle;
            end else begin
              exp_rc <= exp_rc + 4'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: two instances (EXP_LAT=1 and EXP_LAT=3)
// share stimulus; each has its own behavioural AES-256 expander. The driver
// pushes expected values tagged with a cycle number into a scoreboard queue;
// a negedge monitor pops and compares them, and flags any unexpected done.
module tb_aes256_key_sched_ctrl;

  localparam logic [255:0] KeyA =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KeyB =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RkA0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RkA1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RkA14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RkB2  = 128'h9ba354118e6925afa51a8b5f2067fcde;

  localparam int KRk = 0, KRc = 1, KKv = 2, KBusy = 3, KKey = 4, KDone = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n, start;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
`ifdef KSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  logic [3:0]   rc_a, rc_b;
  logic [255:0] key_a, key_b, kout_a, kout_b;
  logic [127:0] rk_a, rk_b;
  logic         busy_a, busy_b, done_a, done_b, kv_a, kv_b;

  // ---------------- behavioural expander ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [255:0] expand(input logic [3:0] rc, input logic [255:0] k);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [7:0]  rb;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32 * i -: 32];
    rb = 8'h01 << (rc - 4'd1);
    n[0] = w[0] ^ subword({w[7][23:0], w[7][31:24]}) ^ {rb, 24'h0};
    for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i - 1];
    n[4] = w[4] ^ subword(n[3]);
    for (int i = 5; i < 8; i++) n[i] = w[i] ^ n[i - 1];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  assign kout_a = expand(rc_a, key_a);
  assign kout_b = expand(rc_b, key_b);

  // Reference round key: hand values where known, otherwise the model.
  function automatic logic [127:0] ref_rk(input logic [255:0] key, input int idx);
    logic [255:0] s;
    if (idx == 15) return '0;
    if (key == KeyA && idx == 0) return RkA0;
    if (key == KeyA && idx == 1) return RkA1;
    if (key == KeyA && idx == 14) return RkA14;
    if (key == KeyB && idx == 2) return RkB2;
    s = key;
    for (int i = 1; i <= idx / 2; i++) s = expand(4'(i), s);
    return idx[0] ? s[127:0] : s[255:128];
  endfunction

  // ---------------- DUTs ----------------
  aes256_key_sched_ctrl #(.EXP_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef KSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_in(key_in), .exp_rc(rc_a), .exp_key(key_a),
    .exp_keyout(kout_a), .rk_idx(rk_idx), .rk_out(rk_a), .busy(busy_a),
    .done(done_a), .keys_valid(kv_a)
  );

  aes256_key_sched_ctrl #(.EXP_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef KSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_in(key_in), .exp_rc(rc_b), .exp_key(key_b),
    .exp_keyout(kout_b), .rk_idx(rk_idx), .rk_out(rk_b), .busy(busy_b),
    .done(done_b), .keys_valid(kv_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    int           inst;
    int           kind;
    logic [255:0] val;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic string kname(input int kind);
    case (kind)
      KRk:     return "rk_out";
      KRc:     return "exp_rc";
      KKv:     return "keys_valid";
      KBusy:   return "busy";
      KKey:    return "exp_key";
      default: return "done";
    endcase
  endfunction

  function automatic logic [255:0] actual(input int inst, input int kind);
    case (kind)
      KRk:     return (inst == 0) ? {128'b0, rk_a} : {128'b0, rk_b};
      KRc:     return (inst == 0) ? {252'b0, rc_a} : {252'b0, rc_b};
      KKv:     return (inst == 0) ? {255'b0, kv_a} : {255'b0, kv_b};
      KBusy:   return (inst == 0) ? {255'b0, busy_a} : {255'b0, busy_b};
      KKey:    return (inst == 0) ? key_a : key_b;
      default: return (inst == 0) ? {255'b0, done_a} : {255'b0, done_b};
    endcase
  endfunction

  always @(negedge clk) begin
    logic         seen [2];
    logic [255:0] act;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        act = actual(sbq[i].inst, sbq[i].kind);
        checks++;
        if (sbq[i].cyc < cyc || act !== sbq[i].val) begin
          errors++;
          $display("FAIL %s inst%0d cyc%0d: got %h, want %h", kname(sbq[i].kind),
                   sbq[i].inst, sbq[i].cyc, act, sbq[i].val);
        end
        if (sbq[i].kind == KDone) seen[sbq[i].inst] = 1'b1;
        sbq.delete(i);
      end
    end
    if (done_a === 1'b1 && !seen[0]) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done inst0 cyc%0d: got 1, want 0", cyc);
    end
    if (done_b === 1'b1 && !seen[1]) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done inst1 cyc%0d: got 1, want 0", cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int dc, input int inst, input int kind, input logic [255:0] v);
    item_t it;
    it.cyc  = cyc + dc;
    it.inst = inst;
    it.kind = kind;
    it.val  = v;
    sbq.push_back(it);
  endtask

  task automatic push2(input int dc, input int kind, input logic [255:0] v);
    push(dc, 0, kind, v);
    push(dc, 1, kind, v);
  endtask

  task automatic randomize_inputs();
    start  = 1'($urandom);
    rk_idx = 4'($urandom);
    for (int j = 0; j < 8; j++) key_in[32 * j +: 32] = $urandom;
  endtask

  // Starts a schedule on the next edge; full=1 also expects it to complete.
  task automatic launch(input logic [255:0] key, input bit full);
    logic [255:0] s1;
    start  = 1'b1;
    key_in = key;
    s1     = expand(4'd1, key);
    push2(1, KBusy, 256'd1);
    push2(1, KKv, 256'd0);
    push2(1, KKey, key);
    push(1, 0, KRc, 256'd1);
    push(1, 1, KRc, 256'd1);
    if (full) begin
      for (int c = 1; c < 7; c++) push(1 + c, 0, KRc, 256'(1 + c));
      push(8, 0, KDone, 256'd1);
      push(8, 0, KBusy, 256'd0);
      push(8, 0, KKv, 256'd1);
      push(8, 0, KRc, 256'd0);
      for (int c = 1; c < 21; c++) push(1 + c, 1, KRc, 256'(1 + c / 3));
      for (int c = 3; c < 6; c++) push(1 + c, 1, KKey, s1);
      push(22, 1, KDone, 256'd1);
      push(22, 1, KBusy, 256'd0);
      push(22, 1, KKv, 256'd1);
      push(22, 1, KRc, 256'd0);
    end
  endtask

  task automatic sweep(input logic [255:0] key, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rk_idx = 4'(i);
      push2(1, KRk, {128'b0, ref_rk(key, i)});
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
`ifdef KSCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    randomize_inputs();

    // Reset with random inputs.
    for (int r = 0; r < 2; r++) begin
      tick(1);
      randomize_inputs();
      push2(0, KBusy, 256'd0);
      push2(0, KDone, 256'd0);
      push2(0, KKv, 256'd0);
      push2(0, KRc, 256'd0);
      push2(0, KRk, 256'd0);
      push2(0, KKey, 256'd0);
    end
    rst_n  = 1'b1;
    start  = 1'b0;
    rk_idx = 4'd0;
    tick(2);

    // FIPS-197 key, full sweep.
    launch(KeyA, 1'b1);
    tick(1);
    start = 1'b0;
    tick(21);
    sweep(KeyA, 0, 14);

    // Second key with a start pulse while busy, plus reads during the run.
    launch(KeyB, 1'b1);
    tick(1);
    start = 1'b0;
    tick(2);
    start  = 1'b1;
    key_in = KeyA;
    rk_idx = 4'd3;
    push2(1, KRk, 256'd0);
    tick(1);
    start = 1'b0;
    tick(18);
    sweep(KeyB, 0, 15);

    // Abort mid-schedule, then a fresh schedule.
    launch(KeyA, 1'b0);
    tick(1);
    start = 1'b0;
    tick(3);
    rst_n  = 1'b0;
    rk_idx = 4'd0;
    push2(1, KBusy, 256'd0);
    push2(1, KKv, 256'd0);
    push2(1, KRc, 256'd0);
    push2(1, KKey, 256'd0);
    push2(1, KRk, 256'd0);
    tick(1);
    rst_n = 1'b1;
    push2(1, KKv, 256'd0);
    tick(6);
    launch(KeyB, 1'b1);
    tick(1);
    start = 1'b0;
    tick(21);
    sweep(KeyB, 0, 2);
    sweep(KeyB, 13, 14);

`ifdef KSCHED_ZEROIZE_EN
    zeroize = 1'b1;
    push2(1, KKv, 256'd0);
    push2(1, KBusy, 256'd0);
    push2(1, KRk, 256'd0);
    tick(1);
    zeroize = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rk_idx = 4'(i);
      push2(1, KRk, 256'd0);
      tick(1);
    end
    zeroize = 1'b1;
    start   = 1'b1;
    key_in  = KeyA;
    push2(1, KBusy, 256'd0);
    push2(1, KRc, 256'd0);
    tick(1);
    zeroize = 1'b0;
    start   = 1'b0;
    push2(1, KBusy, 256'd0);
    push2(1, KKv, 256'd0);
    tick(1);
`endif

    tick(4);
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked_%s inst%0d cyc%0d: got none, want %h", kname(sbq[0].kind),
               sbq[0].inst, sbq[0].cyc, sbq[0].val);
      void'(sbq.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
